// File: rtl/hdc_perf_pkg.sv
// hdc_perf_pkg: shared helpers for the HDC stream performance monitor.
//  MAX_LABELS  widest label vector the popcount helper accepts
//  MAX_W       widest counter/timestamp the saturating adder accepts
//  sat_add     a + b clamped to lim (a assumed <= lim)
//  popcount    number of set bits in a label-mismatch vector
package hdc_perf_pkg;

  localparam int unsigned MAX_LABELS = 32;
  localparam int unsigned MAX_W      = 64;

  // Clamp instead of wrapping; the comparison form avoids needing a carry bit at MAX_W.
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input logic [MAX_W-1:0] lim);
    if (b > (lim - a)) return lim;
    return a + b;
  endfunction

  function automatic logic [MAX_W-1:0] popcount(input logic [MAX_LABELS-1:0] v);
    logic [MAX_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(MAX_LABELS); i++) n = n + MAX_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/hdc_perf_ts_fifo.sv
// hdc_perf_ts_fifo: DEPTH-entry synchronous FIFO holding timestamped entries.
//  clk, rst       clock, synchronous active-high reset (pointers/count only)
//  push, pop      requests; push while full is accepted only with a same-cycle pop,
//                 pop while empty is ignored
//  wdata          entry to store
//  rdata_c        head entry (combinational read of storage)
//  full_c,empty_c occupancy flags decoded from the count register
//  count          registered occupancy, 0..DEPTH
module hdc_perf_ts_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 34
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign rdata_c = mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty_c;
  assign push_ok = push & (~full_c | pop_ok);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale entries are never read because count gates pops.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/hdc_stream_perf_monitor.sv
// hdc_stream_perf_monitor: passive valid/ready monitor for an HDC classifier.
// Timestamps accepted inputs, pairs outputs with inputs in order, and reports
// stall/idle statistics, latency and label-mismatch statistics. All outputs are
// registered; nothing is driven back onto the snooped handshakes.
//  clk, rst, clear                  clock, sync active-high reset, sync soft clear
//  fin_valid/ready, exp_labels      snooped input handshake + expected labels
//  dout_valid/ready, dout_labels    snooped output handshake + produced labels
//  fin/dout_stall_cnt, _idle_cnt    saturating handshake statistics
//  done_cnt, fail_cnt, fail_mask    completed entries, mismatched bits, sticky mask
//  lat_last, lat_max, lat_total     latency statistics (total saturates)
//  in_flight, overflow, underflow   tracker occupancy and sticky error flags
module hdc_stream_perf_monitor
  import hdc_perf_pkg::*;
#(
  parameter int unsigned NUM_LABELS = 2,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CYC_W      = 32,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    fin_valid,
  input  logic                    fin_ready,
  input  logic [NUM_LABELS-1:0]   exp_labels,
  input  logic                    dout_valid,
  input  logic                    dout_ready,
  input  logic [NUM_LABELS-1:0]   dout_labels,
  output logic [CNT_W-1:0]        fin_stall_cnt,
  output logic [CNT_W-1:0]        fin_idle_cnt,
  output logic [CNT_W-1:0]        dout_stall_cnt,
  output logic [CNT_W-1:0]        dout_idle_cnt,
  output logic [CNT_W-1:0]        done_cnt,
  output logic [CNT_W-1:0]        fail_cnt,
  output logic [NUM_LABELS-1:0]   fail_mask,
  output logic [CYC_W-1:0]        lat_last,
  output logic [CYC_W-1:0]        lat_max,
  output logic [CNT_W-1:0]        lat_total,
  output logic [$clog2(DEPTH):0]  in_flight,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned EW = CYC_W + NUM_LABELS;
  localparam logic [MAX_W-1:0] CNT_MAX = MAX_W'({CNT_W{1'b1}});

  typedef struct packed {
    logic [CYC_W-1:0]      ts;
    logic [NUM_LABELS-1:0] labels;
  } entry_t;

  function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] a,
                                               input logic [MAX_W-1:0] b);
    return CNT_W'(sat_add(MAX_W'(a), b, CNT_MAX));
  endfunction

  logic                  sync_rst;
  logic                  fin_hs;
  logic                  dout_hs;
  logic                  full_c;
  logic                  empty_c;
  logic                  pop_valid;
  logic [CYC_W-1:0]      cycle;
  logic [CYC_W-1:0]      lat_c;
  logic [NUM_LABELS-1:0] mm_c;
  entry_t                wr_entry;
  entry_t                rd_entry;
  logic [EW-1:0]         rd_raw;

  assign sync_rst = rst | clear;
  assign fin_hs   = fin_valid & fin_ready;
  assign dout_hs  = dout_valid & dout_ready;

  assign wr_entry  = '{ts: cycle, labels: exp_labels};
  assign rd_entry  = entry_t'(rd_raw);
  // Pops against an empty tracker are flagged only; they never touch the statistics.
  assign pop_valid = dout_hs & ~empty_c;
  assign lat_c     = cycle - rd_entry.ts;
  assign mm_c      = dout_labels ^ rd_entry.labels;

  hdc_perf_ts_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (sync_rst),
    .push    (fin_hs),
    .pop     (dout_hs),
    .wdata   (wr_entry),
    .rdata_c (rd_raw),
    .full_c  (full_c),
    .empty_c (empty_c),
    .count   (in_flight)
  );

  // Cycle counter, handshake statistics and pairing results.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      cycle          <= '0;
      fin_stall_cnt  <= '0;
      fin_idle_cnt   <= '0;
      dout_stall_cnt <= '0;
      dout_idle_cnt  <= '0;
      done_cnt       <= '0;
      fail_cnt       <= '0;
      fail_mask      <= '0;
      lat_last       <= '0;
      lat_max        <= '0;
      lat_total      <= '0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      cycle <= cycle + CYC_W'(1);

      if (fin_valid & ~fin_ready)   fin_stall_cnt  <= cnt_add(fin_stall_cnt, MAX_W'(1));
      if (~fin_valid & fin_ready)   fin_idle_cnt   <= cnt_add(fin_idle_cnt, MAX_W'(1));
      if (dout_valid & ~dout_ready) dout_stall_cnt <= cnt_add(dout_stall_cnt, MAX_W'(1));
      if (~dout_valid & dout_ready) dout_idle_cnt  <= cnt_add(dout_idle_cnt, MAX_W'(1));

      if (pop_valid) begin
        lat_last  <= lat_c;
        if (lat_c > lat_max) lat_max <= lat_c;
        lat_total <= cnt_add(lat_total, MAX_W'(lat_c));
        done_cnt  <= cnt_add(done_cnt, MAX_W'(1));
        fail_cnt  <= cnt_add(fail_cnt, popcount(MAX_LABELS'(mm_c)));
        fail_mask <= fail_mask | mm_c;
      end

      // Full implies non-empty, so a dout handshake always frees a slot here.
      if (fin_hs & full_c & ~dout_hs) overflow  <= 1'b1;
      if (dout_hs & empty_c)          underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hdc_stream_perf_monitor.sv
// Bench for hdc_stream_perf_monitor: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
// A second instance with an 8-bit cycle counter exercises timestamp wrap.
module tb_hdc_stream_perf_monitor;

  localparam int DEPTH = 8;
  localparam longint CMAX = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst, clear;
  logic fin_valid, fin_ready, dout_valid, dout_ready;
  logic [1:0] exp_labels, dout_labels;

  logic [31:0] fin_stall_cnt, fin_idle_cnt, dout_stall_cnt, dout_idle_cnt;
  logic [31:0] done_cnt, fail_cnt, lat_last, lat_max, lat_total;
  logic [1:0]  fail_mask;
  logic [3:0]  in_flight;
  logic        overflow, underflow;

  logic [31:0] s_fin_stall, s_fin_idle, s_dout_stall, s_dout_idle;
  logic [31:0] s_done, s_fail, s_lat_total;
  logic [7:0]  s_lat_last, s_lat_max;
  logic [1:0]  s_mask;
  logic [3:0]  s_in_flight;
  logic        s_ovf, s_unf;

  always #5 clk = ~clk;

  hdc_stream_perf_monitor dut (
    .clk(clk), .rst(rst), .clear(clear),
    .fin_valid(fin_valid), .fin_ready(fin_ready), .exp_labels(exp_labels),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_labels(dout_labels),
    .fin_stall_cnt(fin_stall_cnt), .fin_idle_cnt(fin_idle_cnt),
    .dout_stall_cnt(dout_stall_cnt), .dout_idle_cnt(dout_idle_cnt),
    .done_cnt(done_cnt), .fail_cnt(fail_cnt), .fail_mask(fail_mask),
    .lat_last(lat_last), .lat_max(lat_max), .lat_total(lat_total),
    .in_flight(in_flight), .overflow(overflow), .underflow(underflow)
  );

  hdc_stream_perf_monitor #(.CYC_W(8)) dut8 (
    .clk(clk), .rst(rst), .clear(clear),
    .fin_valid(fin_valid), .fin_ready(fin_ready), .exp_labels(exp_labels),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_labels(dout_labels),
    .fin_stall_cnt(s_fin_stall), .fin_idle_cnt(s_fin_idle),
    .dout_stall_cnt(s_dout_stall), .dout_idle_cnt(s_dout_idle),
    .done_cnt(s_done), .fail_cnt(s_fail), .fail_mask(s_mask),
    .lat_last(s_lat_last), .lat_max(s_lat_max), .lat_total(s_lat_total),
    .in_flight(s_in_flight), .overflow(s_ovf), .underflow(s_unf)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint     ts;
    logic [1:0] lab;
  } ent_t;

  ent_t   q[$];
  ent_t   e;
  longint m_cyc, m_fin_stall, m_fin_idle, m_dout_stall, m_dout_idle;
  longint m_done, m_fail, m_lat_last, m_lat_max, m_lat_total, m_lat_last8, m_lat_max8;
  longint lat, lat8;
  logic [1:0] m_mask, mm;
  bit m_ovf, m_unf, started, push, pop_ok, push_ok;

  function automatic longint sat(input longint v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic longint bits2(input logic [1:0] v);
    return longint'(v[0]) + longint'(v[1]);
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (rst || clear) begin
      q.delete();
      m_cyc = 0; m_fin_stall = 0; m_fin_idle = 0; m_dout_stall = 0; m_dout_idle = 0;
      m_done = 0; m_fail = 0; m_lat_last = 0; m_lat_max = 0; m_lat_total = 0;
      m_lat_last8 = 0; m_lat_max8 = 0; m_mask = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (fin_valid && !fin_ready)   m_fin_stall  = sat(m_fin_stall + 1);
      if (!fin_valid && fin_ready)   m_fin_idle   = sat(m_fin_idle + 1);
      if (dout_valid && !dout_ready) m_dout_stall = sat(m_dout_stall + 1);
      if (!dout_valid && dout_ready) m_dout_idle  = sat(m_dout_idle + 1);
      push   = fin_valid && fin_ready;
      pop_ok = dout_valid && dout_ready && q.size() > 0;
      if (dout_valid && dout_ready && q.size() == 0) m_unf = 1;
      if (push && q.size() == DEPTH && !pop_ok) m_ovf = 1;
      push_ok = push && (q.size() < DEPTH || pop_ok);
      if (pop_ok) begin
        e    = q.pop_front();
        lat  = (m_cyc - e.ts) % (64'd1 << 32);
        lat8 = (m_cyc - e.ts) % 256;
        mm   = dout_labels ^ e.lab;
        m_lat_last  = lat;
        m_lat_max   = (lat > m_lat_max) ? lat : m_lat_max;
        m_lat_last8 = lat8;
        m_lat_max8  = (lat8 > m_lat_max8) ? lat8 : m_lat_max8;
        m_lat_total = sat(m_lat_total + lat);
        m_done      = sat(m_done + 1);
        m_fail      = sat(m_fail + bits2(mm));
        m_mask      = m_mask | mm;
      end
      if (push_ok) q.push_back('{m_cyc, exp_labels});
      m_cyc++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("fin_stall_cnt", fin_stall_cnt, m_fin_stall);
      chk("fin_idle_cnt", fin_idle_cnt, m_fin_idle);
      chk("dout_stall_cnt", dout_stall_cnt, m_dout_stall);
      chk("dout_idle_cnt", dout_idle_cnt, m_dout_idle);
      chk("done_cnt", done_cnt, m_done);
      chk("fail_cnt", fail_cnt, m_fail);
      chk("fail_mask", fail_mask, m_mask);
      chk("lat_last", lat_last, m_lat_last);
      chk("lat_max", lat_max, m_lat_max);
      chk("lat_total", lat_total, m_lat_total);
      chk("in_flight", in_flight, q.size());
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_unf);
      chk("w8_lat_last", s_lat_last, m_lat_last8);
      chk("w8_lat_max", s_lat_max, m_lat_max8);
      chk("w8_in_flight", s_in_flight, q.size());
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic fr, input logic [1:0] el,
                       input logic dv, input logic dr, input logic [1:0] dl);
    fin_valid = fv; fin_ready = fr; exp_labels = el;
    dout_valid = dv; dout_ready = dr; dout_labels = dl;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 2'b00, 0, 0, 2'b00);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_clear();
    drive(0, 0, 2'b00, 0, 0, 2'b00);
    clear = 1; tick(); clear = 0;
  endtask

  int pp;

  initial begin
    rst = 1; clear = 0;
    drive(0, 0, 2'b00, 0, 0, 2'b00);
    tick(); tick();
    chk("reset_done", done_cnt, 0);
    chk("reset_lat_last", lat_last, 0);
    rst = 0;

    // 1: push at cycle 10, pop at cycle 17 with matching labels
    idle(10);
    drive(1, 1, 2'b10, 0, 0, 2'b00); tick();
    idle(6);
    drive(0, 0, 2'b00, 1, 1, 2'b10); tick();
    idle(1);
    chk("t1_lat_last", lat_last, 7);
    chk("t1_done", done_cnt, 1);
    chk("t1_fail", fail_cnt, 0);

    // 2: two-bit mismatch, then a clean entry
    do_clear();
    drive(1, 1, 2'b11, 0, 0, 2'b00); tick();
    drive(0, 0, 2'b00, 1, 1, 2'b00); tick();
    idle(1);
    chk("t2_fail", fail_cnt, 2);
    chk("t2_mask", fail_mask, 3);
    drive(1, 1, 2'b01, 0, 0, 2'b00); tick();
    drive(0, 0, 2'b00, 1, 1, 2'b01); tick();
    idle(1);
    chk("t2_fail_after_match", fail_cnt, 2);
    chk("t2_done", done_cnt, 2);

    // 3: nine pushes into an eight-deep tracker, then drain
    do_clear();
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 2'($urandom), 0, 0, 2'b00); tick();
    end
    chk("t3_in_flight_full", in_flight, 8);
    chk("t3_overflow", overflow, 1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 2'b00, 1, 1, 2'($urandom)); tick();
    end
    chk("t3_in_flight_empty", in_flight, 0);
    chk("t3_lat_last", lat_last, 9);
    chk("t3_lat_total", lat_total, 72);
    chk("t3_done", done_cnt, 8);

    // 4: pop on empty tracker with simultaneous push
    do_clear();
    drive(1, 1, 2'b01, 1, 1, 2'b10); tick();
    idle(1);
    chk("t4_underflow", underflow, 1);
    chk("t4_done", done_cnt, 0);
    chk("t4_in_flight", in_flight, 1);

    // 5: back-pressure on both sides
    do_clear();
    drive(1, 0, 2'b00, 1, 0, 2'b00); tick(); tick(); tick();
    drive(1, 0, 2'b00, 0, 0, 2'b00); tick(); tick();
    idle(1);
    chk("t5_fin_stall", fin_stall_cnt, 5);
    chk("t5_dout_stall", dout_stall_cnt, 3);
    chk("t5_fin_idle", fin_idle_cnt, 0);

    // 6: timestamp wrap on the 8-bit instance, then clear mid-stream
    do_clear();
    idle(250);
    drive(1, 1, 2'b00, 0, 0, 2'b00); tick();
    idle(9);
    drive(0, 0, 2'b00, 1, 1, 2'b00); tick();
    idle(1);
    chk("t6_w8_lat_last", s_lat_last, 10);
    chk("t6_lat_last", lat_last, 10);
    drive(1, 1, 2'b11, 0, 0, 2'b00); tick(); tick();
    drive(1, 1, 2'b11, 0, 0, 2'b00);
    clear = 1; tick(); clear = 0;
    idle(0);
    chk("t6_clear_in_flight", in_flight, 0);
    chk("t6_clear_done", done_cnt, 0);
    chk("t6_clear_lat_max", lat_max, 0);
    chk("t6_clear_w8_lat_last", s_lat_last, 0);
    drive(0, 0, 2'b00, 1, 1, 2'b00); tick();
    idle(1);
    chk("t6_underflow_after_clear", underflow, 1);

    // randomized traffic with alternating drain bias and rare clears
    do_clear();
    for (int c = 0; c < 4000; c++) begin
      pp = ((c / 400) % 2 == 0) ? 80 : 30;
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70, 2'($urandom),
            $urandom_range(0, 99) < pp, $urandom_range(0, 99) < 75, 2'($urandom));
      clear = ($urandom_range(0, 999) == 0);
      tick();
    end
    clear = 0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
